// File: rtl/disk_bridge_if.sv
// CPU data bus seen by the disk bridge: strobe/acknowledge handshake plus address and data.
// Handshake: the master raises STB with stable WE/ADDR/DAT_I and holds it until it sees ACK;
// the slave holds ACK only while STB stays high; STB must be low for a cycle between transfers.
interface disk_bridge_if #(
    parameter int DATA_W = 32
) ();
    logic              WE;
    logic              STB;
    logic              ACK;
    logic [31:0]       ADDR;
    logic [DATA_W-1:0] DAT_I;
    logic [DATA_W-1:0] DAT_O;

    modport master (output WE, STB, ADDR, DAT_I, input ACK, DAT_O);
    modport slave  (input WE, STB, ADDR, DAT_I, output ACK, DAT_O);
endinterface

// File: rtl/disk_bridge.sv
// Bus slave bridging the CPU bus to the disk buffer and a command/status register pair.
// One disk operation at a time; the bus stalls in ISSUE/WAIT until the disk finishes or times out.
module disk_bridge #(
    parameter  int DATA_W  = 32,
    parameter  int BUF_AW  = 7,
    parameter  int NDISK   = 2,
    parameter  int BLK_W   = 24,
    parameter  int TMO_CYC = 4096,
    localparam int DSEL_W  = (NDISK > 1) ? $clog2(NDISK) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    disk_bridge_if.slave        bus,
    output logic [DATA_W-1:0]   instruction,
    output logic [DSEL_W-1:0]   disk_sel,
    output logic                write_pause,
    output logic                read_pause,
    input  logic                disk_operate_done,
    output logic [BUF_AW+1:0]   disk_addr,
    input  logic [DATA_W-1:0]   disk_data_in,
    output logic [DATA_W-1:0]   disk_data_out,
    output logic [1:0]          state_dbg
);
    localparam int TMR_W = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACKING} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [TMR_W-1:0]   timer;
    logic               tmo_err;
    logic               sel_err;
    logic               last_dir;
    logic               status_rd;

    logic               cmd_rgn;
    logic               cmd_wr;
    logic               stat_rd;
    logic [DSEL_W-1:0]  cmd_disk;
    logic               sel_bad;
    logic               tmo_hit;
    logic               busy;
    logic [DATA_W-1:0]  cmd_word;
    logic [DATA_W-1:0]  status_word;
    logic               unused_addr;

    assign cmd_rgn     = bus.ADDR[BUF_AW+2];
    assign cmd_wr      = cmd_rgn && !bus.ADDR[2] && bus.WE;
    assign stat_rd     = cmd_rgn && bus.ADDR[2] && !bus.WE;
    assign cmd_disk    = bus.DAT_I[DATA_W-2 -: DSEL_W];
    assign sel_bad     = (int'(cmd_disk) >= NDISK);
    assign tmo_hit     = (TMO_CYC != 0) && (timer == TMR_W'(TMO_CYC - 1));
    assign busy        = (state == ISSUE) || (state == WAIT);
    assign status_word = DATA_W'({sel_err, last_dir, tmo_err, busy});
    assign unused_addr = ^{bus.ADDR[31:BUF_AW+3], bus.ADDR[1:0]};

    assign disk_addr     = {bus.ADDR[BUF_AW+1:2], 2'b00};
    assign disk_data_out = bus.DAT_I;
    assign write_pause   = (state == ISSUE) && last_dir;
    assign read_pause    = (state == ISSUE) && !last_dir;
    assign bus.ACK       = (state == ACKING) && bus.STB;
    assign state_dbg     = state;

    // Latched command keeps only dir, disk and block fields; padding reads back as zero.
    always_comb begin
        cmd_word                        = '0;
        cmd_word[DATA_W-1]              = bus.DAT_I[DATA_W-1];
        cmd_word[DATA_W-2 -: DSEL_W]    = cmd_disk;
        cmd_word[BLK_W-1:0]             = bus.DAT_I[BLK_W-1:0];
    end

    always_comb begin
        bus.DAT_O = disk_data_in;
        if (cmd_rgn) begin
            bus.DAT_O = bus.ADDR[2] ? status_word : instruction;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.STB) begin
                    state_nxt = (cmd_wr && !sel_bad) ? ISSUE : ACKING;
                end
            end
            ISSUE:  state_nxt = WAIT;
            WAIT: begin
                if (disk_operate_done || tmo_hit) begin
                    state_nxt = ACKING;
                end
            end
            ACKING: begin
                if (!bus.STB) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Sticky status bits clear when a STATUS read leaves ACKING, so DAT_O is stable under ACK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instruction <= '0;
            disk_sel    <= '0;
            timer       <= '0;
            tmo_err     <= 1'b0;
            sel_err     <= 1'b0;
            last_dir    <= 1'b0;
            status_rd   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.STB) begin
                        status_rd <= stat_rd;
                        if (cmd_wr) begin
                            instruction <= cmd_word;
                            disk_sel    <= cmd_disk;
                            last_dir    <= bus.DAT_I[DATA_W-1];
                            if (sel_bad) begin
                                sel_err <= 1'b1;
                            end
                        end
                    end
                end
                ISSUE: timer <= '0;
                WAIT: begin
                    if (timer != {TMR_W{1'b1}}) begin
                        timer <= timer + TMR_W'(1);
                    end
                    if (tmo_hit && !disk_operate_done) begin
                        tmo_err <= 1'b1;
                    end
                end
                ACKING: begin
                    if (!bus.STB && status_rd) begin
                        tmo_err <= 1'b0;
                        sel_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_disk_bridge.sv
// Randomized bench for disk_bridge: transaction-level model of latency, pulses, and register contents.
module tb_disk_bridge;
    localparam int TMO   = 16;
    localparam int NDISK = 3;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic [1:0]  disk_sel;
    logic        write_pause;
    logic        read_pause;
    logic        disk_operate_done;
    logic [8:0]  disk_addr;
    logic [31:0] disk_data_in;
    logic [31:0] disk_data_out;
    logic [1:0]  state_dbg;

    disk_bridge_if #(.DATA_W(32)) bus ();

    disk_bridge #(.DATA_W(32), .BUF_AW(7), .NDISK(NDISK), .BLK_W(24), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .instruction(instruction), .disk_sel(disk_sel),
        .write_pause(write_pause), .read_pause(read_pause),
        .disk_operate_done(disk_operate_done), .disk_addr(disk_addr),
        .disk_data_in(disk_data_in), .disk_data_out(disk_data_out), .state_dbg(state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Disk-side buffer and responder
    logic [31:0] mem [128];
    assign disk_data_in = mem[disk_addr[8:2]];
    int resp_delay;

    initial begin : responder
        int dl;
        disk_operate_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && (write_pause || read_pause) && resp_delay > 0) begin
                dl = resp_delay;
                repeat (dl) @(posedge clk);
                #1 disk_operate_done = 1'b1;
                @(posedge clk);
                #1 disk_operate_done = 1'b0;
            end
        end
    end

    // Scoreboard
    int checks;
    int errors;
    int wp_cnt;
    int rp_cnt;
    logic ack_prev;
    logic [31:0] exp_q[$];

    logic [31:0] m_instr;
    logic [1:0]  m_disk;
    logic        m_dir;
    logic        m_tmo;
    logic        m_sel;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        return {28'b0, m_sel, m_dir, m_tmo, 1'b0};
    endfunction

    task automatic model_reset();
        m_instr = '0; m_disk = '0; m_dir = 1'b0; m_tmo = 1'b0; m_sel = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("disk_addr", {23'b0, disk_addr}, {23'b0, bus.ADDR[8:2], 2'b00});
            check("disk_data_out", disk_data_out, bus.DAT_I);
            check("pause_excl", {31'b0, write_pause & read_pause}, 32'h0);
            if (!bus.STB) check("ack_without_stb", {31'b0, bus.ACK}, 32'h0);
            wp_cnt += int'(write_pause);
            rp_cnt += int'(read_pause);
            if (bus.ACK && !ack_prev) begin
                if (exp_q.size() == 0) check("unexpected_ack", 32'h1, 32'h0);
                else check("dat_o", bus.DAT_O, exp_q.pop_front());
            end
            ack_prev = bus.ACK;
        end else begin
            ack_prev = 1'b0;
        end
    end

    // Driver: one bus transfer; d = disk response delay (0 = never), drop = release STB mid-op
    task automatic bus_xfer(input bit we, input logic [31:0] addr, input logic [31:0] data,
                            input int d, input bit drop, output int n);
        int lat, exp_w, exp_r, w0, r0, hold;
        logic [31:0] exp_d;
        bit is_cmd_wr, is_stat_rd;
        lat = 1; exp_w = 0; exp_r = 0;
        is_cmd_wr  = we && addr[9] && !addr[2];
        is_stat_rd = !we && addr[9] && addr[2];
        if (is_cmd_wr) begin
            m_instr = data & 32'hE0FF_FFFF;
            m_disk  = data[30:29];
            m_dir   = data[31];
            if (int'(m_disk) >= NDISK) begin
                m_sel = 1'b1;
            end else begin
                exp_w = int'(data[31]);
                exp_r = int'(!data[31]);
                if (d == 0 || d > TMO) begin
                    lat = 2 + TMO;
                    m_tmo = 1'b1;
                end else begin
                    lat = 2 + d;
                end
            end
        end
        if (!addr[9]) exp_d = mem[addr[8:2]];
        else if (addr[2]) exp_d = model_status();
        else exp_d = m_instr;
        if (is_stat_rd) begin
            m_tmo = 1'b0;
            m_sel = 1'b0;
        end
        if (!drop) exp_q.push_back(exp_d);
        resp_delay = is_cmd_wr ? d : 0;
        @(posedge clk); #1;
        w0 = wp_cnt; r0 = rp_cnt;
        bus.ADDR = addr; bus.WE = we; bus.DAT_I = data; bus.STB = 1'b1;
        n = 0;
        if (drop) begin
            repeat (3) @(posedge clk);
            #1 bus.STB = 1'b0; bus.WE = 1'b0;
            repeat (24) @(negedge clk);
        end else begin
            @(negedge clk);
            while (!bus.ACK && n < lat + 5) begin
                n++;
                @(negedge clk);
            end
            check("ack_seen", {31'b0, bus.ACK}, 32'h1);
            check("ack_latency", n, lat);
            hold = $urandom_range(0, 2);
            repeat (hold) begin
                @(negedge clk);
                check("ack_hold", {31'b0, bus.ACK}, 32'h1);
            end
            @(posedge clk); #1 bus.STB = 1'b0; bus.WE = 1'b0;
            @(negedge clk);
            check("ack_release", {31'b0, bus.ACK}, 32'h0);
        end
        check("write_pulses", wp_cnt - w0, exp_w);
        check("read_pulses", rp_cnt - r0, exp_r);
        if (is_cmd_wr) begin
            check("instruction", instruction, m_instr);
            check("disk_sel", {30'b0, disk_sel}, {30'b0, m_disk});
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n;
        int kind;
        logic [31:0] a;
        logic [31:0] dt;
        checks = 0; errors = 0; wp_cnt = 0; rp_cnt = 0; ack_prev = 1'b0;
        resp_delay = 0;
        model_reset();
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        bus.STB = 1'b0; bus.WE = 1'b0; bus.ADDR = '0; bus.DAT_I = '0;
        rst_n = 1'b0;
        #2;
        check("rst_ack", {31'b0, bus.ACK}, 32'h0);
        check("rst_instr", instruction, 32'h0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Buffer write at 0x08: one-cycle latency
        bus_xfer(1'b1, 32'h08, 32'hDEAD_BEEF, 0, 1'b0, n);
        check("pin_buf_lat", n, 1);
        // Disk-0 write command completing after 12 cycles
        bus_xfer(1'b1, 32'h200, 32'h8000_0005, 12, 1'b0, n);
        check("pin_cmd_lat", n, 14);
        check("pin_model_st_wr", model_status(), 32'h4);
        bus_xfer(1'b0, 32'h204, 32'h0, 0, 1'b0, n);
        // Read command that never completes: timeout
        bus_xfer(1'b1, 32'h200, 32'h0000_0007, 0, 1'b0, n);
        check("pin_tmo_lat", n, 18);
        check("pin_model_st_tmo", model_status(), 32'h2);
        bus_xfer(1'b0, 32'h204, 32'h0, 0, 1'b0, n);
        check("pin_model_st_clr", model_status(), 32'h0);
        bus_xfer(1'b0, 32'h204, 32'h0, 0, 1'b0, n);
        // Disk 3 out of range
        bus_xfer(1'b1, 32'h200, 32'hE000_0009, 5, 1'b0, n);
        check("pin_sel_lat", n, 1);
        check("pin_model_st_sel", model_status(), 32'hC);
        bus_xfer(1'b0, 32'h204, 32'h0, 0, 1'b0, n);
        // Done in IDLE is ignored; then done coinciding with timeout wins
        @(posedge clk); #1 disk_operate_done = 1'b1;
        @(posedge clk); #1 disk_operate_done = 1'b0;
        bus_xfer(1'b0, 32'h204, 32'h0, 0, 1'b0, n);
        bus_xfer(1'b1, 32'h200, 32'h2000_0033, TMO, 1'b0, n);
        check("pin_edge_lat", n, 18);
        bus_xfer(1'b0, 32'h204, 32'h0, 0, 1'b0, n);
        bus_xfer(1'b0, 32'h200, 32'h0, 0, 1'b0, n);
        // STB released mid-operation
        bus_xfer(1'b1, 32'h200, 32'h8000_0001, 8, 1'b1, n);
        bus_xfer(1'b0, 32'h204, 32'h0, 0, 1'b0, n);
        check("pin_after_drop_lat", n, 1);

        // Async reset in the middle of WAIT
        resp_delay = 10;
        @(posedge clk); #1;
        bus.ADDR = 32'h200; bus.WE = 1'b1; bus.DAT_I = 32'h8000_0001; bus.STB = 1'b1;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_mid_ack", {31'b0, bus.ACK}, 32'h0);
        check("rst_mid_wp", {31'b0, write_pause}, 32'h0);
        check("rst_mid_rp", {31'b0, read_pause}, 32'h0);
        check("rst_mid_instr", instruction, 32'h0);
        check("rst_mid_sel", {30'b0, disk_sel}, 32'h0);
        bus.STB = 1'b0; bus.WE = 1'b0;
        model_reset();
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (15) @(posedge clk);
        bus_xfer(1'b0, 32'h204, 32'h0, 0, 1'b0, n);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 4);
            a = {23'b0, 7'($urandom_range(0, 127)), 2'b00};
            dt = $urandom;
            case (kind)
                0: bus_xfer(1'b0, a, dt, 0, 1'b0, n);
                1: bus_xfer(1'b1, a, dt, 0, 1'b0, n);
                2: bus_xfer(1'b1, 32'h200, dt, $urandom_range(0, 18), 1'b0, n);
                3: bus_xfer(1'b0, 32'h200, dt, 0, 1'b0, n);
                default: bus_xfer(1'($urandom_range(0, 1)), 32'h204, dt, 0, 1'b0, n);
            endcase
        end

        repeat (3) @(posedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
